// File: rtl/mmio_timer.sv
// Memory-mapped 32-bit timer: prescaled up-counter, compare match with a sticky flag,
// optional auto-reload and a level interrupt, decoded from the core's data-memory bus.
module mmio_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0800
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  output logic        hit,
  output logic [31:0] rd,
  output logic        irq
);

  logic        w_hit;
  logic        w_wr_ctrl;
  logic        w_wr_count;
  logic        w_wr_cmp;
  logic        w_wr_stat;
  logic        w_tick;
  logic        w_match;
  logic        w_unused;

  logic        r_en;
  logic        r_ar;
  logic        r_ien;
  logic [7:0]  r_presc;
  logic [7:0]  r_pcnt;
  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic        r_flag;

  assign w_hit      = (addr[31:4] == BASE_ADDR[31:4]);
  assign w_wr_ctrl  = we && w_hit && (addr[3:2] == 2'd0);
  assign w_wr_count = we && w_hit && (addr[3:2] == 2'd1);
  assign w_wr_cmp   = we && w_hit && (addr[3:2] == 2'd2);
  assign w_wr_stat  = we && w_hit && (addr[3:2] == 2'd3);
  assign w_unused   = &{1'b0, addr[1:0]};

  // A CTRL write restarts the prescaler, so it also suppresses the tick of that cycle.
  assign w_tick  = r_en && !w_wr_ctrl && (r_pcnt == r_presc);
  assign w_match = w_tick && (r_count == r_compare);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_en      <= 1'b0;
      r_ar      <= 1'b0;
      r_ien     <= 1'b0;
      r_presc   <= 8'd0;
      r_pcnt    <= 8'd0;
      r_count   <= 32'd0;
      r_compare <= 32'hFFFF_FFFF;
      r_flag    <= 1'b0;
    end else begin
      if (w_wr_ctrl) begin
        r_en    <= wd[0];
        r_ar    <= wd[1];
        r_ien   <= wd[2];
        r_presc <= wd[15:8];
        r_pcnt  <= 8'd0;
      end else if (!r_en || w_tick) begin
        r_pcnt  <= 8'd0;
      end else begin
        r_pcnt  <= r_pcnt + 8'd1;
      end

      if (w_wr_count) begin
        r_count <= wd;
      end else if (w_tick) begin
        r_count <= (w_match && r_ar) ? 32'd0 : r_count + 32'd1;
      end

      if (w_wr_cmp) begin
        r_compare <= wd;
      end

      // Setting the flag takes priority over a simultaneous write-1-to-clear.
      if (w_match) begin
        r_flag <= 1'b1;
      end else if (w_wr_stat && wd[0]) begin
        r_flag <= 1'b0;
      end
    end
  end

  always_comb begin
    rd = 32'd0;
    if (w_hit) begin
      case (addr[3:2])
        2'd0:    rd = {16'd0, r_presc, 5'd0, r_ien, r_ar, r_en};
        2'd1:    rd = r_count;
        2'd2:    rd = r_compare;
        default: rd = {31'd0, r_flag};
      endcase
    end
  end

  assign hit = w_hit;
  assign irq = r_flag & r_ien;

endmodule

// File: tb/tb_mmio_timer.sv
// Randomized bench for mmio_timer: every driven cycle queues the expected hit/rd/irq from a
// reference model; a negedge monitor pops and compares against the DUT outputs.
module tb_mmio_timer;

  logic        clock = 1'b0;
  logic        reset;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wd;
  logic        hit;
  logic [31:0] rd;
  logic        irq;

  always #5 clock = ~clock;

  mmio_timer #(.BASE_ADDR(32'h0000_0800)) dut (
    .clock(clock),
    .reset(reset),
    .we(we),
    .addr(addr),
    .wd(wd),
    .hit(hit),
    .rd(rd),
    .irq(irq)
  );

  typedef struct packed {
    logic        hit;
    logic [31:0] rd;
    logic        irq;
    logic [31:0] addr;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: timer fields plus the absolute edge number of the next tick.
  logic        m_en, m_ar, m_ien, m_flag;
  logic [7:0]  m_presc;
  logic [31:0] m_count, m_cmp;
  int          m_edge = 0;
  int          m_next = 0;

  function automatic bit m_hit(input logic [31:0] a);
    return a[31:4] == 28'h000_0080;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (!m_hit(a)) return 32'd0;
    case (a[3:2])
      2'd0:    return {16'd0, m_presc, 5'd0, m_ien, m_ar, m_en};
      2'd1:    return m_count;
      2'd2:    return m_cmp;
      default: return {31'd0, m_flag};
    endcase
  endfunction

  function automatic void m_update(input logic r, input logic w, input logic [31:0] a,
                                   input logic [31:0] d);
    bit wr, tick, match;
    m_edge++;
    if (r) begin
      {m_en, m_ar, m_ien, m_flag} = 4'b0;
      m_presc = 8'd0;
      m_count = 32'd0;
      m_cmp   = 32'hFFFF_FFFF;
      return;
    end
    wr    = w && m_hit(a);
    tick  = m_en && !(wr && a[3:2] == 2'd0) && (m_edge == m_next);
    match = tick && (m_count == m_cmp);
    if (tick) begin
      m_count = (match && m_ar) ? 32'd0 : m_count + 32'd1;
      m_next  = m_edge + int'(m_presc) + 1;
    end
    if (wr && a[3:2] == 2'd3 && d[0]) m_flag = 1'b0;
    if (match) m_flag = 1'b1;
    if (wr && a[3:2] == 2'd1) m_count = d;
    if (wr && a[3:2] == 2'd2) m_cmp = d;
    if (wr && a[3:2] == 2'd0) begin
      m_en    = d[0];
      m_ar    = d[1];
      m_ien   = d[2];
      m_presc = d[15:8];
      m_next  = m_edge + int'(d[15:8]) + 1;
    end
  endfunction

  function automatic bit tick_next();
    return m_en && (m_edge + 1 == m_next);
  endfunction

  task automatic step(input logic r, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input bit chk);
    exp_t e;
    reset = r;
    we    = w;
    addr  = a;
    wd    = d;
    if (chk) begin
      e.hit  = m_hit(a);
      e.rd   = m_read(a);
      e.irq  = m_flag && m_ien;
      e.addr = a;
      q.push_back(e);
    end
    @(posedge clock);
    #1;
    m_update(r, w, a, d);
  endtask

  task automatic rd_n(input logic [31:0] a, input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, a, 32'd0, 1'b1);
  endtask

  task automatic wr1(input logic [31:0] a, input logic [31:0] d);
    step(1'b0, 1'b1, a, d, 1'b1);
  endtask

  task automatic wait_tick(input bit need_match);
    int i;
    for (i = 0; i < 300; i++) begin
      if (tick_next() && (!need_match || m_count == m_cmp)) break;
      step(1'b0, 1'b0, 32'h804, 32'd0, 1'b1);
    end
    checks++;
    if (i >= 300) begin
      errors++;
      $display("FAIL wait_tick timed out match=%0d", need_match);
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (hit !== e.hit || rd !== e.rd || irq !== e.irq) begin
        errors++;
        $display("FAIL access addr=%h got hit=%b rd=%h irq=%b expected hit=%b rd=%h irq=%b",
                 e.addr, hit, rd, irq, e.hit, e.rd, e.irq);
      end
    end
  end

  initial begin
    logic [31:0] a, d;
    int          r, off;
    reset = 1'b1;
    we    = 1'b0;
    addr  = 32'h800;
    wd    = 32'd0;
    @(posedge clock);
    #1;
    step(1'b1, 1'b0, 32'h800, 32'd0, 1'b0);

    // Reset values and an out-of-window read
    rd_n(32'h800, 1); rd_n(32'h804, 1); rd_n(32'h808, 1); rd_n(32'h80C, 1); rd_n(32'h900, 1);

    // Prescaled count, then freeze
    wr1(32'h800, 32'h0000_0301);
    rd_n(32'h804, 10);
    wr1(32'h800, 32'h0);
    rd_n(32'h804, 5);

    // Auto-reload match with interrupt
    wr1(32'h808, 32'd5);
    wr1(32'h804, 32'd0);
    wr1(32'h800, 32'h0000_0007);
    for (int i = 0; i < 10; i++) begin rd_n(32'h804, 1); rd_n(32'h80C, 1); end
    wait_tick(1'b1);
    wr1(32'h80C, 32'h1);
    rd_n(32'h80C, 2);
    wr1(32'h80C, 32'h1);
    rd_n(32'h80C, 2);
    wr1(32'h80C, 32'h0);
    rd_n(32'h80C, 1);

    // COUNT write on a tick edge wins over the increment
    wait_tick(1'b0);
    wr1(32'h804, 32'h100);
    rd_n(32'h804, 2);

    // Free-running wrap with a late match
    wr1(32'h800, 32'h0);
    wr1(32'h80C, 32'h1);
    wr1(32'h804, 32'hFFFF_FFFE);
    wr1(32'h808, 32'h10);
    wr1(32'h800, 32'h1);
    for (int i = 0; i < 12; i++) begin rd_n(32'h804, 1); rd_n(32'h80C, 1); end

    // Reset mid-operation
    wr1(32'h800, 32'h5);
    wr1(32'h804, 32'h20);
    rd_n(32'h80C, 2);
    step(1'b1, 1'b1, 32'h804, 32'h1234, 1'b1);
    rd_n(32'h800, 1); rd_n(32'h808, 1); rd_n(32'h80C, 1);
    rd_n(32'h804, 6);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      r   = int'($urandom_range(0, 99));
      off = int'($urandom_range(0, 3));
      a   = 32'h800 + 32'(off * 4) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) a = $urandom();
      case (off)
        0:       d = {$urandom_range(0, 65535), 5'd0, 8'($urandom_range(0, 3)), 3'($urandom_range(0, 7))} >> 0;
        1:       d = ($urandom_range(0, 1) == 0) ? m_cmp - 32'($urandom_range(0, 4)) : $urandom();
        2:       d = 32'($urandom_range(0, 12));
        default: d = $urandom();
      endcase
      if (off == 0) begin
        d = {16'($urandom()), 8'($urandom_range(0, 3)), 5'($urandom()), 3'($urandom())};
        if ($urandom_range(0, 3) != 0) d[0] = 1'b1;
      end
      if (r < 2)       step(1'b1, 1'($urandom_range(0, 1)), a, d, 1'b1);
      else if (r < 25) step(1'b0, 1'b1, a, d, 1'b1);
      else             step(1'b0, 1'b0, a, 32'($urandom()), 1'b1);
    end

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
